// File: rtl/cart_route_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : cart_route_scheduler
// Description : Queues cart target positions and paces single-step moves,
//               dwells at each target, and drives the two-LED position display.
// Revision    : 1.0 - initial release
// ============================================================================
module cart_route_scheduler #(
    parameter int TICK_DIV = 4,
    parameter int DWELL    = 8,
    parameter int QDEPTH   = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [2:0] TGT,
    input  logic       TGT_VALID,
    output logic       TGT_READY,
    input  logic       HOLD,
    output logic       STEP_R,
    output logic       STEP_L,
    output logic [2:0] IDX,
    output logic [7:0] POS,
    output logic       ARRIVED,
    output logic       BUSY,
    output logic       ERR
);

    localparam int c_TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int c_AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

    localparam logic [c_TW-1:0] c_TICK_LAST  = c_TW'(TICK_DIV - 1);
    localparam logic [c_DW-1:0] c_DWELL_LAST = c_DW'(DWELL - 1);
    localparam logic [c_AW-1:0] c_PTR_LAST   = c_AW'(QDEPTH - 1);
    localparam logic [c_AW:0]   c_QFULL      = (c_AW + 1)'(QDEPTH);
    localparam logic [2:0]      c_TGT_MAX    = 3'd6;
    localparam logic [7:0]      c_POS_HOME   = 8'hC0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_MOVE  = 2'd2,
        S_DWELL = 2'd3
    } state_t;

    state_t          r_state;
    logic [2:0]      r_mem [QDEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic [2:0]      r_target;
    logic [2:0]      r_idx;
    logic [7:0]      r_pos;
    logic [c_TW-1:0] r_tick_cnt;
    logic [c_DW-1:0] r_dwell_cnt;
    logic            r_step_r;
    logic            r_step_l;
    logic            r_arrived;
    logic            r_err;

    logic            w_full;
    logic            w_empty;
    logic            w_xfer;
    logic            w_push;
    logic            w_bad;
    logic            w_pop;
    logic            w_step_right;
    logic [2:0]      w_next_idx;

    assign w_full       = (r_count == c_QFULL);
    assign w_empty      = (r_count == '0);
    assign w_xfer       = TGT_VALID && !w_full;
    // An out-of-range index is consumed on the handshake but never queued.
    assign w_push       = w_xfer && (TGT <= c_TGT_MAX);
    assign w_bad        = w_xfer && (TGT > c_TGT_MAX);
    assign w_pop        = (r_state == S_IDLE) && !w_empty;
    assign w_step_right = (r_target > r_idx);
    assign w_next_idx   = w_step_right ? (r_idx + 3'd1) : (r_idx - 3'd1);

    assign TGT_READY = !w_full;
    assign BUSY      = (r_state != S_IDLE) || !w_empty;
    assign STEP_R    = r_step_r;
    assign STEP_L    = r_step_l;
    assign IDX       = r_idx;
    assign POS       = r_pos;
    assign ARRIVED   = r_arrived;
    assign ERR       = r_err;

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= TGT;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= S_IDLE;
            r_target    <= '0;
            r_idx       <= '0;
            r_pos       <= c_POS_HOME;
            r_tick_cnt  <= '0;
            r_dwell_cnt <= '0;
            r_step_r    <= 1'b0;
            r_step_l    <= 1'b0;
            r_arrived   <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_step_r  <= 1'b0;
            r_step_l  <= 1'b0;
            r_arrived <= 1'b0;
            if (w_bad) begin
                r_err <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_target <= r_mem[r_rd_ptr];
                        r_state  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (r_target == r_idx) begin
                        r_arrived   <= 1'b1;
                        r_dwell_cnt <= '0;
                        r_state     <= S_DWELL;
                    end else begin
                        r_tick_cnt <= '0;
                        r_state    <= S_MOVE;
                    end
                end
                S_MOVE: begin
                    if (!HOLD) begin
                        if (r_tick_cnt == c_TICK_LAST) begin
                            r_tick_cnt <= '0;
                            r_idx      <= w_next_idx;
                            r_pos      <= c_POS_HOME >> w_next_idx;
                            r_step_r   <= w_step_right;
                            r_step_l   <= !w_step_right;
                            if (w_next_idx == r_target) begin
                                r_arrived   <= 1'b1;
                                r_dwell_cnt <= '0;
                                r_state     <= S_DWELL;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                end
                S_DWELL: begin
                    if (!HOLD) begin
                        if (r_dwell_cnt == c_DWELL_LAST) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_dwell_cnt <= r_dwell_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cart_route_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_cart_route_scheduler
// Description : Directed self-checking bench for cart_route_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cart_route_scheduler;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [2:0] TGT = 3'd0;
    logic       TGT_VALID = 1'b0;
    logic       TGT_READY;
    logic       HOLD = 1'b0;
    logic       STEP_R;
    logic       STEP_L;
    logic [2:0] IDX;
    logic [7:0] POS;
    logic       ARRIVED;
    logic       BUSY;
    logic       ERR;

    cart_route_scheduler #(.TICK_DIV(4), .DWELL(8), .QDEPTH(4)) dut (
        .CLK(CLK), .RESET(RESET), .TGT(TGT), .TGT_VALID(TGT_VALID),
        .TGT_READY(TGT_READY), .HOLD(HOLD), .STEP_R(STEP_R), .STEP_L(STEP_L),
        .IDX(IDX), .POS(POS), .ARRIVED(ARRIVED), .BUSY(BUSY), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int cyc;
        bit right;
        int idx;
        int pos;
    } ev_t;

    ev_t evq[$];
    int  arr_cyc[$];
    int  arr_idx[$];
    int  cyc = 0;
    int  fall_cyc = -1;
    int  both_hot = 0;
    bit  prev_busy = 1'b0;
    int  n_cmp = 0;
    int  n_bad = 0;

    // Edge-numbered event log, sampled 1 time unit after each rising edge.
    always @(posedge CLK) begin
        cyc++;
        #1;
        if (!RESET) begin
            if (STEP_R && STEP_L) both_hot++;
            if (STEP_R) evq.push_back('{cyc, 1'b1, int'(IDX), int'(POS)});
            if (STEP_L) evq.push_back('{cyc, 1'b0, int'(IDX), int'(POS)});
            if (ARRIVED) begin
                arr_cyc.push_back(cyc);
                arr_idx.push_back(int'(IDX));
            end
            if (prev_busy && !BUSY) fall_cyc = cyc;
        end
        prev_busy = BUSY;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int ev_field(input int i, input int which);
        if (i >= evq.size()) return -1;
        case (which)
            0: return evq[i].cyc;
            1: return int'(evq[i].right);
            2: return evq[i].idx;
            default: return evq[i].pos;
        endcase
    endfunction

    function automatic int arr_field(input int i, input bit want_idx);
        if (i >= arr_cyc.size()) return -1;
        return want_idx ? arr_idx[i] : arr_cyc[i];
    endfunction

    task automatic clear_log();
        evq.delete();
        arr_cyc.delete();
        arr_idx.delete();
        fall_cyc = -1;
    endtask

    task automatic apply_reset();
        TGT_VALID = 1'b0;
        HOLD      = 1'b0;
        RESET     = 1'b1;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        clear_log();
    endtask

    // Called at a falling edge; returns the edge number of the transfer.
    task automatic push(input logic [2:0] t, output int acc);
        int g;
        g = 0;
        TGT       = t;
        TGT_VALID = 1'b1;
        while (!TGT_READY && g < 200) begin
            @(negedge CLK);
            g++;
        end
        check("push_ready_wait", {31'd0, TGT_READY}, 32'd1);
        acc = cyc + 1;
        @(negedge CLK);
        TGT_VALID = 1'b0;
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while (BUSY && g < 400) begin
            @(negedge CLK);
            g++;
        end
        check("idle_timeout", {31'd0, BUSY}, 32'd0);
    endtask

    int k, k2;
    int a[5];
    int tseq[5] = '{2, 4, 1, 3, 0};

    initial begin
        // Reset state
        @(negedge CLK);
        apply_reset();
        check("rst_idx", 32'(IDX), 32'd0);
        check("rst_pos", 32'(POS), 32'hC0);
        check("rst_ready", 32'(TGT_READY), 32'd1);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_step_r", 32'(STEP_R), 32'd0);
        check("rst_step_l", 32'(STEP_L), 32'd0);
        check("rst_arrived", 32'(ARRIVED), 32'd0);
        check("rst_err", 32'(ERR), 32'd0);

        // Full rightward traverse to 6
        push(3'd6, k);
        wait_idle();
        check("t6_nstrobe", 32'(evq.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            check("t6_cyc", 32'(ev_field(i, 0)), 32'(k + 6 + 4 * i));
            check("t6_dir", 32'(ev_field(i, 1)), 32'd1);
            check("t6_idx", 32'(ev_field(i, 2)), 32'(i + 1));
            check("t6_pos", 32'(ev_field(i, 3)), 32'(8'hC0 >> (i + 1)));
        end
        check("t6_arr_cyc", 32'(arr_field(0, 1'b0)), 32'(k + 26));
        check("t6_narr", 32'(arr_cyc.size()), 32'd1);
        check("t6_busy_fall", 32'(fall_cyc), 32'(k + 34));

        // Two-leg route 3 then 1
        apply_reset();
        push(3'd3, k);
        push(3'd1, k2);
        check("r31_b2b", 32'(k2), 32'(k + 1));
        wait_idle();
        check("r31_nstrobe", 32'(evq.size()), 32'd5);
        for (int i = 0; i < 3; i++) begin
            check("r31_r_cyc", 32'(ev_field(i, 0)), 32'(k + 6 + 4 * i));
            check("r31_r_dir", 32'(ev_field(i, 1)), 32'd1);
        end
        check("r31_pos_at3", 32'(ev_field(2, 3)), 32'h18);
        check("r31_l0_cyc", 32'(ev_field(3, 0)), 32'(k + 28));
        check("r31_l0_dir", 32'(ev_field(3, 1)), 32'd0);
        check("r31_l0_pos", 32'(ev_field(3, 3)), 32'h30);
        check("r31_l1_cyc", 32'(ev_field(4, 0)), 32'(k + 32));
        check("r31_l1_dir", 32'(ev_field(4, 1)), 32'd0);
        check("r31_l1_pos", 32'(ev_field(4, 3)), 32'h60);
        check("r31_arr0", 32'(arr_field(0, 1'b0)), 32'(k + 14));
        check("r31_arr1", 32'(arr_field(1, 1'b0)), 32'(k + 32));

        // Five back-to-back targets fill the queue
        apply_reset();
        for (int i = 0; i < 5; i++) push(3'(tseq[i]), a[i]);
        check("q5_consecutive", 32'(a[4]), 32'(a[0] + 4));
        check("q5_ready_full", 32'(TGT_READY), 32'd0);
        wait_idle();
        check("q5_narr", 32'(arr_cyc.size()), 32'd5);
        for (int i = 0; i < 5; i++) check("q5_order", 32'(arr_field(i, 1'b1)), 32'(tseq[i]));
        check("q5_ready_after", 32'(TGT_READY), 32'd1);

        // Out-of-range target, then a zero-distance target
        apply_reset();
        push(3'd7, k);
        check("e7_err", 32'(ERR), 32'd1);
        check("e7_busy", 32'(BUSY), 32'd0);
        check("e7_ready", 32'(TGT_READY), 32'd1);
        push(3'd0, k);
        wait_idle();
        check("z0_nstrobe", 32'(evq.size()), 32'd0);
        check("z0_arr_cyc", 32'(arr_field(0, 1'b0)), 32'(k + 2));
        check("z0_busy_fall", 32'(fall_cyc), 32'(k + 10));
        check("z0_err_sticky", 32'(ERR), 32'd1);

        // HOLD mid-move, then reset mid-move
        apply_reset();
        check("h_err_cleared", 32'(ERR), 32'd0);
        push(3'd6, k);
        while (cyc < k + 10) @(negedge CLK);
        HOLD = 1'b1;
        repeat (10) @(negedge CLK);
        HOLD = 1'b0;
        check("h_idx_frozen", 32'(IDX), 32'd2);
        check("h_nstrobe", 32'(evq.size()), 32'd2);
        while (cyc < k + 29) @(negedge CLK);
        check("h_s3_cyc", 32'(ev_field(2, 0)), 32'(k + 24));
        check("h_s4_cyc", 32'(ev_field(3, 0)), 32'(k + 28));
        check("h_s4_idx", 32'(ev_field(3, 2)), 32'd4);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        check("mr_idx", 32'(IDX), 32'd0);
        check("mr_pos", 32'(POS), 32'hC0);
        check("mr_busy", 32'(BUSY), 32'd0);
        check("mr_ready", 32'(TGT_READY), 32'd1);
        repeat (20) @(negedge CLK);
        check("mr_no_more_steps", 32'(evq.size()), 32'd4);
        check("mr_still_idle", 32'(BUSY), 32'd0);

        check("never_both_strobes", 32'(both_hot), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cart_route_scheduler.md
Name: cart_route_scheduler

Overview:
Sequences the railway cart datapath along a queued route of target positions. Accepts target indices through a valid/ready port into a small FIFO. Paces single-step left/right moves with a programmable tick divider and dwells at each target. Drives the 8-bit two-LED cart position display and issues per-step strobes to downstream logic.

Parameters:
TICK_DIV, 4, clock cycles per cart step while moving (>=1)
DWELL, 8, clock cycles spent stopped at a reached target (>=1)
QDEPTH, 4, target FIFO depth (power of 2)

Ports:
CLK  input  1  system clock, rising edge
RESET  input  1  synchronous, active-high reset
TGT  input  3  target position index, 0 = leftmost, 6 = rightmost
TGT_VALID  input  1  TGT is presented
TGT_READY  output  1  FIFO can accept; transfer on TGT_VALID & TGT_READY
HOLD  input  1  pause: freezes step and dwell counting
STEP_R  output  1  one-cycle strobe, cart moved one position right
STEP_L  output  1  one-cycle strobe, cart moved one position left
IDX  output  3  current cart index 0..6
POS  output  8  display, 8'b1100_0000 >> IDX
ARRIVED  output  1  one-cycle pulse on reaching a target
BUSY  output  1  state != IDLE or FIFO non-empty
ERR  output  1  sticky, an out-of-range target (7) was offered and dropped

Behaviour:
- One clock, CLK. RESET is synchronous and active-high, sampled on the CLK rising edge.
- Reset (synchronous, any state): state=IDLE, IDX=0, POS=8'hC0, STEP_R=STEP_L=0, ARRIVED=0, ERR=0, FIFO flushed, counters cleared. TGT_READY=1 and BUSY=0 the cycle after reset.
- FIFO:
  - TGT_READY = !full (combinational).
  - Push on VALID&READY with TGT<=6.
  - A transfer with TGT==7 is consumed, not stored, and sets ERR.
  - Push and pop in the same cycle is allowed; the count is unchanged.
  - When full, READY=0 and the producer holds TGT/TGT_VALID.
- States: IDLE, LOAD, MOVE, DWELL.
  - IDLE: FIFO non-empty -> pop head into the target register, go to LOAD.
  - LOAD: target==IDX -> ARRIVED=1 next cycle, go to DWELL. Otherwise clear the tick counter and go to MOVE.
  - MOVE: tick counter increments on each cycle with HOLD=0. On the cycle it reaches TICK_DIV-1:
    - counter wraps to 0;
    - IDX+=1 with STEP_R=1 if target>IDX, else IDX-=1 with STEP_L=1;
    - the strobe and the IDX/POS update occur on the same edge.
  - MOVE exit: if the updated IDX==target, go to DWELL with ARRIVED=1 on that same edge.
  - DWELL: dwell counter counts DWELL cycles (HOLD=0 cycles only), then go to IDLE.
- Latency:
  - Target accepted at edge k (FIFO was empty, state IDLE) -> popped at edge k+1 -> LOAD->MOVE at edge k+2.
  - First step strobe at edge k+2+TICK_DIV.
  - A move of distance d takes d*TICK_DIV MOVE cycles.
- Outputs: STEP_R, STEP_L, ARRIVED and POS are registered. STEP_R and STEP_L are never both 1. IDX never leaves 0..6; no wrap-around.
- HOLD:
  - In MOVE and DWELL it freezes counters; no strobes are issued.
  - IDLE still pops and LOAD still transitions.
  - FIFO pushes continue.
- RESET mid-MOVE or mid-DWELL: immediate return to reset values. The queued route is lost.
- ERR clears only on RESET.

Test Plan:
- Reset asserted 2 cycles, then released -> IDX=0, POS=8'hC0, TGT_READY=1, BUSY=0, no strobes, ERR=0.
- Push TGT=6 (TICK_DIV=4, DWELL=8) -> six STEP_R pulses 4 cycles apart, first at 6 cycles after accept. POS steps C0,60,30,18,0C,06,03. ARRIVED with the 6th strobe; BUSY falls 8 cycles later.
- Push 3 then 1 back-to-back -> 3 STEP_R (POS=8'h18), ARRIVED, 8-cycle dwell, 2 STEP_L (POS=8'h60), second ARRIVED; no STEP_R in the leftward leg.
- Push 5 targets in consecutive cycles while IDLE with QDEPTH=4 -> TGT_READY drops after the 4th is stored (one was popped, so the 5th is accepted one cycle later). The producer holds; all 5 targets are visited in order.
- Push TGT=7 -> ERR=1, FIFO count unchanged, no strobes. Then push TGT=0 at IDX=0 -> no strobe, ARRIVED one cycle after LOAD, dwell 8.
- Target 6, HOLD=1 for 10 cycles after the 2nd strobe -> no strobes, IDX=2 frozen; resumes with the same phase. RESET asserted mid-move -> IDX=0, POS=8'hC0, FIFO empty, BUSY=0.
